// File: rtl/vga_sync_gen_pkg.sv
// Default 640x480@60 VGA timing constants, counter width and the RGB pixel type.
// Shared by the sync generator, its per-axis timer and the pin-side interface.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 15;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 49;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 9;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 34;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int CNT_W    = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel-side bus of the sync generator: colour in, coordinates/sync/blanked RGB out.
// master = generator, slave = draw logic / pin driver.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    rgb_t             rgb_in;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             activeH;
    logic             activeV;
    logic             Hsync;
    logic             Vsync;
    logic [3:0]       vgaRed;
    logic [3:0]       vgaGreen;
    logic [3:0]       vgaBlue;
    logic             line_end;
    logic             frame_end;

    modport master (
        input  rgb_in,
        output x, y, activeH, activeV, Hsync, Vsync,
        output vgaRed, vgaGreen, vgaBlue, line_end, frame_end
    );

    modport slave (
        output rgb_in,
        input  x, y, activeH, activeV, Hsync, Vsync,
        input  vgaRed, vgaGreen, vgaBlue, line_end, frame_end
    );

endinterface

// File: rtl/vga_sync_gen_axis_timer.sv
// One timing axis: wrapping counter advanced by inc, plus active/sync decodes.
// Decodes are combinational from the counter register; reset forces the idle (active, unsynced) state.
module vga_axis_timer
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE   = 640,
    parameter int FP       = 15,
    parameter int SYNC     = 96,
    parameter int BP       = 49,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             greset,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             active,
    output logic             sync
);

    localparam int               TOTAL   = ACTIVE + FP + SYNC + BP;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(ACTIVE + FP + SYNC - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             in_sync;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (greset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign in_sync = ~greset & (count_q >= SYNC_LO) & (count_q <= SYNC_HI);

    assign count  = count_q;
    assign wrap   = inc & ~greset & (count_q == LAST);
    assign active = greset | (count_q < ACT_END);
    assign sync   = in_sync ? SYNC_POL : ~SYNC_POL;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: x/y counters, Hsync/Vsync, active flags, blanked RGB, line/frame pulses.
// Zero latency from counters to outputs; VGA_SYNC_OUT_FF_EN adds one output register stage (x/y unaffected).
module vga_sync_gen #(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic           clk,
    input  logic           greset,
    vga_sync_gen_if.master vga
);
    import vga_timing_pkg::*;

    logic [CNT_W-1:0] x_cnt;
    logic [CNT_W-1:0] y_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             h_act;
    logic             v_act;
    logic             h_sync;
    logic             v_sync;
    rgb_t             rgb_d;

    vga_axis_timer #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(SYNC_POL)
    ) u_h_timer (
        .clk(clk), .greset(greset), .inc(1'b1),
        .count(x_cnt), .wrap(h_wrap), .active(h_act), .sync(h_sync)
    );

    vga_axis_timer #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(SYNC_POL)
    ) u_v_timer (
        .clk(clk), .greset(greset), .inc(h_wrap),
        .count(y_cnt), .wrap(v_wrap), .active(v_act), .sync(v_sync)
    );

    assign vga.x = x_cnt;
    assign vga.y = y_cnt;

    assign rgb_d = (h_act & v_act) ? vga.rgb_in : '0;

`ifdef VGA_SYNC_OUT_FF_EN
    logic h_act_q, v_act_q, h_sync_q, v_sync_q, line_end_q, frame_end_q;
    rgb_t rgb_q;

    // In reset the region reads as active, so the colour register keeps following rgb_in.
    always_ff @(posedge clk) begin
        if (greset) begin
            h_act_q     <= 1'b1;
            v_act_q     <= 1'b1;
            h_sync_q    <= ~SYNC_POL;
            v_sync_q    <= ~SYNC_POL;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
            rgb_q       <= rgb_d;
        end else begin
            h_act_q     <= h_act;
            v_act_q     <= v_act;
            h_sync_q    <= h_sync;
            v_sync_q    <= v_sync;
            line_end_q  <= h_wrap;
            frame_end_q <= v_wrap;
            rgb_q       <= rgb_d;
        end
    end

    assign vga.activeH   = h_act_q;
    assign vga.activeV   = v_act_q;
    assign vga.Hsync     = h_sync_q;
    assign vga.Vsync     = v_sync_q;
    assign vga.line_end  = line_end_q;
    assign vga.frame_end = frame_end_q;
    assign vga.vgaRed    = rgb_q.r;
    assign vga.vgaGreen  = rgb_q.g;
    assign vga.vgaBlue   = rgb_q.b;
`else
    assign vga.activeH   = h_act;
    assign vga.activeV   = v_act;
    assign vga.Hsync     = h_sync;
    assign vga.Vsync     = v_sync;
    assign vga.line_end  = h_wrap;
    assign vga.frame_end = v_wrap;
    assign vga.vgaRed    = rgb_d.r;
    assign vga.vgaGreen  = rgb_d.g;
    assign vga.vgaBlue   = rgb_d.b;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size 640x480 instance and a shrunken, active-high-sync instance
// driven from one reset/colour stream, each checked every cycle against a reference timing model.
module tb_vga_sync_gen;

    typedef struct {
        int hact, hs_lo, hs_hi, htot;
        int vact, vs_lo, vs_hi, vtot;
        int pol;
    } geo_t;

    typedef struct {
        logic [31:0] x, y, ah, av, hs, vs, r, g, b, le, fe;
    } exp_t;

    localparam geo_t G_DEF = '{hact: 640, hs_lo: 655, hs_hi: 750, htot: 800,
                               vact: 480, vs_lo: 489, vs_hi: 490, vtot: 525, pol: 0};
    localparam geo_t G_SML = '{hact: 16, hs_lo: 18, hs_hi: 20, htot: 24,
                               vact: 10, vs_lo: 12, vs_hi: 13, vtot: 17, pol: 1};

    logic        clk = 1'b0;
    logic        greset = 1'b1;
    logic [11:0] rgb_v = 12'hFFF;

    int n_chk = 0;
    int n_err = 0;

    vga_sync_gen_if if_d ();
    vga_sync_gen_if if_s ();

    assign if_d.rgb_in = rgb_v;
    assign if_s.rgb_in = rgb_v;

    vga_sync_gen u_dut_def (
        .clk(clk), .greset(greset), .vga(if_d)
    );

    vga_sync_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b1)
    ) u_dut_sml (
        .clk(clk), .greset(greset), .vga(if_s)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t decode(geo_t g, int hx, int vy, bit rst, logic [11:0] rgb);
        exp_t e;
        bit   vis;
        e.x  = hx;
        e.y  = vy;
        e.ah = (rst || hx < g.hact) ? 1 : 0;
        e.av = (rst || vy < g.vact) ? 1 : 0;
        if (!rst && hx >= g.hs_lo && hx <= g.hs_hi) e.hs = g.pol;
        else                                         e.hs = 1 - g.pol;
        if (!rst && vy >= g.vs_lo && vy <= g.vs_hi) e.vs = g.pol;
        else                                         e.vs = 1 - g.pol;
        vis  = (e.ah == 1) && (e.av == 1);
        e.r  = vis ? {28'd0, rgb[11:8]} : 0;
        e.g  = vis ? {28'd0, rgb[7:4]}  : 0;
        e.b  = vis ? {28'd0, rgb[3:0]}  : 0;
        e.le = (!rst && hx == g.htot - 1) ? 1 : 0;
        e.fe = (!rst && hx == g.htot - 1 && vy == g.vtot - 1) ? 1 : 0;
        return e;
    endfunction

    task automatic adv(inout int h, inout int v, input geo_t g);
        if (h == g.htot - 1) begin
            h = 0;
            v = (v == g.vtot - 1) ? 0 : v + 1;
        end else begin
            h = h + 1;
        end
    endtask

    exp_t q_d[$];
    exp_t q_s[$];

    int   hd = 0, vd = 0, hs_m = 0, vs_m = 0;
    bit   rst_cur = 1'b1;
    exp_t prev_d, prev_s;

    task automatic step(input bit rst, input logic [11:0] rgb);
        exp_t cd, cs, ed, es;
        @(posedge clk);
        if (rst_cur) begin
            hd = 0; vd = 0; hs_m = 0; vs_m = 0;
        end else begin
            adv(hd, vd, G_DEF);
            adv(hs_m, vs_m, G_SML);
        end
        #1;
        greset  = rst;
        rgb_v   = rgb;
        rst_cur = rst;
        cd = decode(G_DEF, hd, vd, rst, rgb);
        cs = decode(G_SML, hs_m, vs_m, rst, rgb);
`ifdef VGA_SYNC_OUT_FF_EN
        ed = prev_d; ed.x = hd;   ed.y = vd;
        es = prev_s; es.x = hs_m; es.y = vs_m;
        prev_d = cd;
        prev_s = cs;
`else
        ed = cd;
        es = cs;
`endif
        q_d.push_back(ed);
        q_s.push_back(es);
    endtask

    task automatic compare(input string who, input exp_t o, input exp_t e);
        check({who, ".x"},         o.x,  e.x);
        check({who, ".y"},         o.y,  e.y);
        check({who, ".activeH"},   o.ah, e.ah);
        check({who, ".activeV"},   o.av, e.av);
        check({who, ".Hsync"},     o.hs, e.hs);
        check({who, ".Vsync"},     o.vs, e.vs);
        check({who, ".vgaRed"},    o.r,  e.r);
        check({who, ".vgaGreen"},  o.g,  e.g);
        check({who, ".vgaBlue"},   o.b,  e.b);
        check({who, ".line_end"},  o.le, e.le);
        check({who, ".frame_end"}, o.fe, e.fe);
    endtask

    int le_obs_d = 0, le_exp_d = 0, fe_obs_s = 0, fe_exp_s = 0;

    always @(negedge clk) begin
        exp_t e, o;
        if (q_d.size() > 0) begin
            e = q_d.pop_front();
            o.x = 32'(if_d.x);  o.y = 32'(if_d.y);
            o.ah = 32'(if_d.activeH); o.av = 32'(if_d.activeV);
            o.hs = 32'(if_d.Hsync);   o.vs = 32'(if_d.Vsync);
            o.r = 32'(if_d.vgaRed); o.g = 32'(if_d.vgaGreen); o.b = 32'(if_d.vgaBlue);
            o.le = 32'(if_d.line_end); o.fe = 32'(if_d.frame_end);
            compare("def", o, e);
            if (o.le == 1) le_obs_d++;
            if (e.le == 1) le_exp_d++;
        end
        if (q_s.size() > 0) begin
            e = q_s.pop_front();
            o.x = 32'(if_s.x);  o.y = 32'(if_s.y);
            o.ah = 32'(if_s.activeH); o.av = 32'(if_s.activeV);
            o.hs = 32'(if_s.Hsync);   o.vs = 32'(if_s.Vsync);
            o.r = 32'(if_s.vgaRed); o.g = 32'(if_s.vgaGreen); o.b = 32'(if_s.vgaBlue);
            o.le = 32'(if_s.line_end); o.fe = 32'(if_s.frame_end);
            compare("sml", o, e);
            if (o.fe == 1) fe_obs_s++;
            if (e.fe == 1) fe_exp_s++;
        end
    end

    initial begin
        prev_d = decode(G_DEF, 0, 0, 1'b1, 12'hFFF);
        prev_s = decode(G_SML, 0, 0, 1'b1, 12'hFFF);

        // Two-clock reset, then a little over two full-size lines of white.
        step(1'b1, 12'hFFF);
        step(1'b1, 12'hFFF);
        for (int i = 0; i < 1700; i++) step(1'b0, 12'hFFF);

        // Changing colours exercise per-channel blanking.
        for (int i = 0; i < 700; i++) step(1'b0, 12'($urandom_range(0, 4095)));

        // Mid-line reset of one clock once the full-size x reaches 300.
        for (int i = 0; i < 800 && hd != 299; i++) step(1'b0, 12'hA5C);
        step(1'b1, 12'h3C9);
        for (int i = 0; i < 1700; i++) step(1'b0, (i % 3 == 0) ? 12'hFFF : 12'h18E);

        // Reset landing on the small instance's frame wrap.
        for (int i = 0; i < 500 && !(hs_m == 22 && vs_m == 16); i++) step(1'b0, 12'hFFF);
        step(1'b0, 12'hFFF);
        step(1'b1, 12'hFFF);
        for (int i = 0; i < 900; i++) step(1'b0, 12'h7E1);

        @(negedge clk);
        @(negedge clk);
        check("def.queue_drained", 32'(q_d.size()), 0);
        check("sml.queue_drained", 32'(q_s.size()), 0);
        check("def.line_end_count", le_obs_d, le_exp_d);
        check("sml.frame_end_count", fe_obs_s, fe_exp_s);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates VGA 640x480 timing (Hsync, Vsync, active-region flags, pixel coordinates) on the 25 MHz pixel clock.
- Blanks the 12-bit RGB to zero outside the active region.
- Sits between the clock divider and the top-level VGA pins. Pixel/draw logic reads x/y and supplies RGB.
- Timing is exactly what the team's sync/RGB checkers expect: 800-clock lines, 525-line frames.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 15, horizontal front porch (clocks)
- H_SYNC, 96, Hsync pulse width (clocks)
- H_BP, 49, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 9, vertical front porch (lines)
- V_SYNC, 2, Vsync pulse width (lines)
- V_BP, 34, vertical back porch (lines)
- SYNC_POL, 0, asserted level of Hsync/Vsync (0 = active low)

Ports:
- clk  in  1  pixel clock, 25 MHz, single clock domain
- greset  in  1  synchronous active-high reset
- rgb_in  in  12  {R,G,B} 4 bits each from draw logic
- x  out  10  current horizontal count, 0..799
- y  out  10  current vertical count, 0..524
- activeH  out  1  high when x < H_ACTIVE
- activeV  out  1  high when y < V_ACTIVE
- Hsync  out  1  horizontal sync
- Vsync  out  1  vertical sync
- vgaRed / vgaGreen / vgaBlue  out  4 each  RGB; zero unless activeH & activeV
- line_end  out  1  one-cycle pulse when x = 799
- frame_end  out  1  one-cycle pulse when x = 799 and y = 524

Behaviour:
- H_TOTAL = 800, V_TOTAL = 525. Both derived from the parameters, not hard-coded.
- Horizontal counter:
  - Increments every clk.
  - At 799 it wraps to 0 and asserts the vertical increment.
- Vertical counter:
  - Increments only on horizontal wrap.
  - At 524 with horizontal wrap, it wraps to 0.
- Hsync is asserted (= SYNC_POL) for x in 655..750; otherwise it is ~SYNC_POL.
- Vsync is asserted for y in 489..490.
- Decodes are combinational from the registered counters, so there is zero latency from counter to outputs.
- RGB outputs = rgb_in when activeH & activeV, else 4'h0 on each channel.
- rgb_in is sampled combinationally against the current x/y. The pixel logic must present the colour for the current (x,y).
- Reset:
  - When greset is high at a clk edge, x = 0 and y = 0 on the next cycle.
  - While in reset: activeH = 1, activeV = 1, Hsync = Vsync = ~SYNC_POL, line_end = frame_end = 0.
  - RGB passes rgb_in while in reset (region is active).
- Reset mid-frame: abandons the frame immediately. The first line after release starts at (0,0) with full 800-clock timing. No partial sync pulse is stretched.
- Simultaneous wraps: at (799,524) both counters wrap in the same cycle, and line_end and frame_end are both high that cycle.
- Counters are 10 bits. Widths are sized so H_TOTAL-1 and V_TOTAL-1 fit, with no overflow beyond the wrap compare.

Optional Feature:
- Macro VGA_SYNC_OUT_FF_EN.
- When defined:
  - Hsync, Vsync, activeH, activeV, the RGB outputs, line_end and frame_end each pass through one output flip-flop, so all lag the counters by exactly 1 clk.
  - x/y remain unregistered counter values.
  - Output FFs reset to the in-reset values listed above.
- When undefined: all outputs are combinational decodes with zero added latency.

Decomposition:
- Package vga_timing_pkg holds:
  - the default timing constants (H_ACTIVE..V_BP, H_TOTAL, V_TOTAL);
  - the counter width constant (10);
  - a typedef for the 12-bit rgb triple.
- One sub-module, vga_axis_timer, instantiated twice:
  - Ports: clk, greset, inc, count, wrap, active, sync.
  - Parameterised with ACTIVE, FP, SYNC, BP, SYNC_POL.
  - The horizontal instance has inc = 1. The vertical instance has inc = horizontal wrap.

Test Plan:
1. Pulse greset high for 2 clks, then release. Check:
   - x counts 0..799.
   - Hsync is low exactly for clocks 655..750 (96 clks).
   - activeH falls at x = 640.
   - line_end is high only at x = 799.
2. Run 525 lines. Check:
   - Vsync is low exactly during lines 489..490 (2*800 clks).
   - activeV is low from line 480.
   - frame_end fires once, at (799,524).
   - Next cycle is (0,0).
3. Hold rgb_in = 12'hFFF. Check:
   - RGB outputs are F/F/F for x < 640 and y < 480.
   - They are 0 for x in 640..799 and all of lines 480..524.
   - The RGB checker's error count stays 0.
4. Assert greset at (300,200) for 1 clk. Check:
   - Next cycle x = 0, y = 0, and Hsync/Vsync are both deasserted (high).
   - Timing resumes; sync checker errors stay 0 for 2 full frames when aligned at release.
5. Build with VGA_SYNC_OUT_FF_EN and repeat tests 1–2. Check:
   - Every Hsync/Vsync/active edge occurs exactly 1 clk later than in the base build.
   - The checker passes with its one-clock FF offset enabled.
